seq_detect_sched: RTL and testbench
===================================

# seq_detect_sched

Round-robin scheduler that shares one serial "two-consecutive-ones" detector (the `S0/S1/S2` FSM block: registered state, synchronous active-high reset, `out`=1 while in `S2`) among `N_REQ` requesters. Each granted requester supplies one `W`-bit word. The block clears the detector, shifts the word into it MSB first, counts the cycles in which the detector output is high, and returns the count with a one-cycle `done` pulse. It sits between the requesting datapath blocks and the single detector instance.

## Interface
- `N_REQ`, default 4: number of requesters, range 2..8.
- `W`, default 8: word width, range 2..32.
- `CW`, default `$clog2(W)`: count width; the maximum count is W-1.

- `clk`, input, 1: single clock; all logic is on the rising edge.
- `rst`, input, 1: reset, asynchronous, active-low.
- `req`, input, N_REQ: per-requester request level.
- `data`, input, N_REQ*W: requester i's word occupies `data[i*W +: W]`.
- `grant`, output, N_REQ: one-hot, registered; identifies the job owner.
- `busy`, output, 1: high in every state except IDLE.
- `done`, output, 1: one-cycle pulse when the result is valid.
- `count`, output, CW: result; holds its value until the next `done`.
- `det_clr`, output, 1: drives the detector's synchronous reset.
- `det_in`, output, 1: serial bit to the detector.
- `det_out`, input, 1: detector output, read back.

## Operation
- The FSM has five states: IDLE, CLR, SHIFT, DRAIN, DONE.
- **IDLE**
  - If `req` != 0, select the winner round-robin: search starts at `ptr+1` and wraps modulo N_REQ.
  - Latch the winner's word into shift register `sreg`.
  - Assert the winner's `grant` bit. Go to CLR.
  - Otherwise stay in IDLE with all outputs 0.
- **CLR** (1 cycle): `det_clr`=1, `det_in`=0. Clear `bitcnt` and the accumulator. Go to SHIFT.
- **SHIFT** (exactly W cycles)
  - `det_in` = `sreg[W-1]`; shift `sreg` left by 1 each cycle.
  - In SHIFT cycles 2..W, add `det_out` to the accumulator. `det_out` in cycle k reflects the bit driven in cycle k-1.
  - After W cycles go to DRAIN.
- **DRAIN** (1 cycle): `det_in`=0. Add `det_out` to the accumulator; this is the response to the last bit. Go to DONE.
- **DONE** (1 cycle): `done`=1, `count` = accumulator, `grant` still asserted. Set `ptr` to the winner. Clear `grant` on exit. Go to IDLE.
- **Result meaning**: `count` is the number of indices i in 1..W-1 with `bit[i-1]` & `bit[i]`, where bit 0 is the MSB.
- **Arithmetic**: the accumulator and `bitcnt` never wrap. The accumulator maximum is W-1; `bitcnt` is sized `$clog2(W+1)`.
- **Request rules**
  - `req` and `data` are sampled only in IDLE.
  - A requester dropping `req` mid-job does not abort the job; `done` is still produced.
  - A requester holding `req` through DONE becomes eligible again, but only after the other pending requesters (fairness).
  - Simultaneous requests are resolved only by the round-robin pointer.
- **Reset** (async, any time, including mid-job)
  - State → IDLE; `ptr` → N_REQ-1, so requester 0 wins first.
  - `grant`, `busy`, `done`, `count`, `det_clr`, `det_in` → 0; `sreg` and the accumulator → 0.
  - The detector's own state is not guaranteed by this reset. The next job's CLR cycle always clears it.

## Timing
- `req` seen in IDLE at edge 0 → `grant`/`busy` high from cycle 1 (CLR).
- SHIFT occupies cycles 2..W+1, DRAIN cycle W+2, DONE cycle W+3.
- A job occupies W+3 cycles, grant to done inclusive.
- The earliest next grant is cycle W+5: IDLE in cycle W+4, CLR in cycle W+5.
- `det_clr` is high only in CLR.
- `det_in` is 0 outside SHIFT.
- `done` is never high for two consecutive cycles.

## Test plan
- **Single word 8'hFF**: reset, then hold `req`=4'b0001 with `data[7:0]`=8'hFF. Expect `grant`=0001 in cycle 1, `det_in`=1 for cycles 2..9, `done` in cycle 11 with `count`=7.
- **Pattern words on requester 2** (W=8): 8'hAA gives `count`=0; 8'hC3 gives `count`=2; 8'b10110111 gives `count`=3.
- **Round-robin under contention**: hold `req`=4'b1111 constantly with distinct words. Grant order is 0,1,2,3,0. Each `count` matches its owner's word, with no idle gaps beyond one IDLE cycle.
- **Request withdrawal**: requester 1 drops `req` in SHIFT cycle 3. The job still completes; `done` occurs in cycle 11 with the correct count; the next grant goes to the next pending requester.
- **Reset mid-SHIFT**: assert `rst`=0 for 1 cycle during SHIFT. All outputs drop to 0 immediately. After release, a new `req` on requester 0 with 8'hFF yields `count`=7; no stale detector state is carried over.
- **Detector dependence**: force `det_out`=1 during CLR and SHIFT cycle 1. These cycles are ignored: `count` for 8'h00 equals 0.

Source files
------------

// File: rtl/seq_detect_sched.sv
// rtl/seq_detect_sched.sv - round-robin scheduler sharing one serial two-consecutive-ones detector
module seq_detect_sched #(
   parameter int N_REQ = 4,
   parameter int W     = 8,
   parameter int CW    = $clog2(W)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_REQ-1:0]     req,
   input  logic [N_REQ*W-1:0]   data,
   output logic [N_REQ-1:0]     grant,
   output logic                 busy,
   output logic                 done,
   output logic [CW-1:0]        count,
   output logic                 det_clr,
   output logic                 det_in,
   input  logic                 det_out
);

   localparam int PW = $clog2(N_REQ);
   localparam int BW = $clog2(W + 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLR   = 3'd1,
      S_SHIFT = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [PW-1:0]   ptr;
   logic [PW-1:0]   owner;
   logic [W-1:0]    sreg;
   logic [BW-1:0]   bitcnt;
   logic [CW-1:0]   acc;
   logic [CW-1:0]   acc_inc;

   logic [PW-1:0]   win_idx;
   logic            win_valid;
   logic [W-1:0]    win_word;
   int              idx;

   // Round-robin winner: scan from ptr+1 upward, wrapping; lowest offset wins,
   // so the loop runs from the farthest offset down and the last hit sticks.
   always_comb begin
      win_idx   = '0;
      win_valid = 1'b0;
      win_word  = '0;
      idx       = 0;
      for (int off = N_REQ; off >= 1; off--) begin
         idx = (int'(ptr) + off) % N_REQ;
         if (req[idx]) begin
            win_idx   = PW'(idx);
            win_valid = 1'b1;
            win_word  = data[idx*W +: W];
         end
      end
   end

   // Saturating increment keeps the accumulator from wrapping even if the
   // detector misbehaves and reports a hit on every sampled cycle.
   always_comb begin
      acc_inc = acc;
      if (det_out && (acc != CW'(W - 1))) begin
         acc_inc = acc + CW'(1);
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode and the state-derived control outputs.
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      det_clr   = 1'b0;
      det_in    = 1'b0;
      done      = 1'b0;
      case (state)
         S_IDLE: begin
            if (win_valid) begin
               state_nxt = S_CLR;
            end
         end
         S_CLR: begin
            busy      = 1'b1;
            det_clr   = 1'b1;
            state_nxt = S_SHIFT;
         end
         S_SHIFT: begin
            busy   = 1'b1;
            det_in = sreg[W-1];
            if (bitcnt == BW'(W - 1)) begin
               state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            busy      = 1'b1;
            state_nxt = S_DONE;
         end
         S_DONE: begin
            busy      = 1'b1;
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Job datapath: latch the winner's word, shift it out, accumulate detector
   // hits (the first SHIFT cycle only shows the post-clear state, so it is
   // skipped), and publish the result when entering DONE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr    <= PW'(N_REQ - 1);
         owner  <= '0;
         grant  <= '0;
         sreg   <= '0;
         bitcnt <= '0;
         acc    <= '0;
         count  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (win_valid) begin
                  sreg  <= win_word;
                  owner <= win_idx;
                  grant <= N_REQ'(1) << win_idx;
               end
            end
            S_CLR: begin
               bitcnt <= '0;
               acc    <= '0;
            end
            S_SHIFT: begin
               sreg   <= sreg << 1;
               bitcnt <= bitcnt + BW'(1);
               if (bitcnt != '0) begin
                  acc <= acc_inc;
               end
            end
            S_DRAIN: begin
               acc   <= acc_inc;
               count <= acc_inc;
            end
            S_DONE: begin
               ptr   <= owner;
               grant <= '0;
            end
            default: begin
               grant <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_detect_sched.sv
// tb/tb_seq_detect_sched.sv - directed self-checking bench for seq_detect_sched
module tb_seq_detect_sched;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [31:0] data;
   logic [3:0]  grant;
   logic        busy;
   logic        done;
   logic [2:0]  count;
   logic        det_clr;
   logic        det_in;
   logic        det_out;

   logic [1:0]  dst;
   logic        force_hi;

   int errors;
   int checks;

   seq_detect_sched #(.N_REQ(4), .W(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .data    (data),
      .grant   (grant),
      .busy    (busy),
      .done    (done),
      .count   (count),
      .det_clr (det_clr),
      .det_in  (det_in),
      .det_out (det_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Detector model: S0/S1/S2, synchronous clear, out high in S2.
   // Starts in S2 to stand in for an unknown power-up state.
   initial dst = 2'd2;
   always @(posedge clk) begin
      if (det_clr) dst <= 2'd0;
      else if (det_in) dst <= (dst == 2'd0) ? 2'd1 : 2'd2;
      else dst <= 2'd0;
   end
   assign det_out = (dst == 2'd2) || force_hi;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      while (done !== 1'b1 && cyc < 40) begin
         tick();
         cyc++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; req = '0; data = '0; force_hi = 1'b0;
      tick(); tick();
      checks++;
      if ({grant, busy, done, count, det_clr, det_in} !== 11'd0) begin
         errors++;
         $display("FAIL reset_outputs got=%b exp=0", {grant, busy, done, count, det_clr, det_in});
      end
      rst = 1'b1;
      tick();
      checks++;
      if (busy !== 1'b0 || grant !== 4'b0000) begin
         errors++;
         $display("FAIL reset_idle busy=%b grant=%b exp busy=0 grant=0000", busy, grant);
      end
   endtask

   task automatic test_single_ff();
      int bad;
      data[7:0] = 8'hFF; req = 4'b0001;
      tick();
      checks++;
      if (grant !== 4'b0001 || busy !== 1'b1 || det_clr !== 1'b1) begin
         errors++;
         $display("FAIL single_cycle1 grant=%b busy=%b det_clr=%b exp 0001/1/1", grant, busy, det_clr);
      end
      bad = 0;
      for (int k = 2; k <= 9; k++) begin
         tick();
         if (det_in !== 1'b1 || det_clr !== 1'b0 || done !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL single_shift_det_in bad_cycles=%0d exp=0", bad);
      end
      tick();
      checks++;
      if (det_in !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL single_drain det_in=%b done=%b busy=%b exp 0/0/1", det_in, done, busy);
      end
      tick();
      checks++;
      if (done !== 1'b1 || count !== 3'd7 || grant !== 4'b0001) begin
         errors++;
         $display("FAIL single_done done=%b count=%0d grant=%b exp 1/7/0001", done, count, grant);
      end
      req = '0;
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || grant !== 4'b0000 || count !== 3'd7) begin
         errors++;
         $display("FAIL single_after done=%b busy=%b grant=%b count=%0d exp 0/0/0000/7", done, busy, grant, count);
      end
   endtask

   task automatic test_patterns();
      logic [7:0] words [3];
      logic [2:0] exp [3];
      int cyc;
      words[0] = 8'hAA; exp[0] = 3'd0;
      words[1] = 8'hC3; exp[1] = 3'd2;
      words[2] = 8'b10110111; exp[2] = 3'd3;
      for (int i = 0; i < 3; i++) begin
         data[23:16] = words[i]; req = 4'b0100;
         wait_done(cyc);
         req = '0;
         checks++;
         if (cyc != 11 || grant !== 4'b0100 || count !== exp[i]) begin
            errors++;
            $display("FAIL pattern_%0d cyc=%0d grant=%b count=%0d exp 11/0100/%0d", i, cyc, grant, count, exp[i]);
         end
         tick();
         checks++;
         if (done !== 1'b0) begin
            errors++;
            $display("FAIL pattern_%0d_done_pulse done=%b exp=0", i, done);
         end
      end
   endtask

   task automatic test_round_robin();
      int order [5];
      logic [2:0] exp [4];
      int cyc;
      order = '{0, 1, 2, 3, 0};
      exp[0] = 3'd2; exp[1] = 3'd1; exp[2] = 3'd7; exp[3] = 3'd4;
      rst = 1'b0; tick(); rst = 1'b1;
      data = {8'h7C, 8'hFF, 8'h03, 8'hE0};
      req = 4'b1111;
      for (int j = 0; j < 5; j++) begin
         wait_done(cyc);
         checks++;
         if (cyc != 11 || grant !== (4'b0001 << order[j]) || count !== exp[order[j]]) begin
            errors++;
            $display("FAIL rr_job_%0d cyc=%0d grant=%b count=%0d exp 11/%b/%0d",
                     j, cyc, grant, count, 4'b0001 << order[j], exp[order[j]]);
         end
         if (j == 4) req = '0;
         tick();
         checks++;
         if (busy !== 1'b0 || grant !== 4'b0000) begin
            errors++;
            $display("FAIL rr_gap_%0d busy=%b grant=%b exp 0/0000", j, busy, grant);
         end
      end
   endtask

   task automatic test_withdrawal();
      int cyc;
      data[15:8] = 8'h6E; data[31:24] = 8'h7C;
      req = 4'b1010;
      for (int k = 1; k <= 4; k++) tick();
      checks++;
      if (grant !== 4'b0010 || busy !== 1'b1) begin
         errors++;
         $display("FAIL wd_grant grant=%b busy=%b exp 0010/1", grant, busy);
      end
      req = 4'b1000;
      wait_done(cyc);
      checks++;
      if (cyc != 7 || count !== 3'd3 || grant !== 4'b0010) begin
         errors++;
         $display("FAIL wd_done cyc=%0d count=%0d grant=%b exp 7/3/0010", cyc, count, grant);
      end
      tick();
      wait_done(cyc);
      req = '0;
      checks++;
      if (cyc != 11 || count !== 3'd4 || grant !== 4'b1000) begin
         errors++;
         $display("FAIL wd_next cyc=%0d count=%0d grant=%b exp 11/4/1000", cyc, count, grant);
      end
      tick();
   endtask

   task automatic test_reset_mid_shift();
      int cyc;
      data[23:16] = 8'hFF; req = 4'b0100;
      for (int k = 1; k <= 4; k++) tick();
      rst = 1'b0;
      #1;
      checks++;
      if ({grant, busy, done, count, det_clr, det_in} !== 11'd0) begin
         errors++;
         $display("FAIL midreset_outputs got=%b exp=0", {grant, busy, done, count, det_clr, det_in});
      end
      req = '0;
      @(posedge clk); #1;
      rst = 1'b1;
      data[7:0] = 8'hFF; req = 4'b0001;
      wait_done(cyc);
      req = '0;
      checks++;
      if (cyc != 11 || count !== 3'd7 || grant !== 4'b0001) begin
         errors++;
         $display("FAIL midreset_job cyc=%0d count=%0d grant=%b exp 11/7/0001", cyc, count, grant);
      end
      tick();
   endtask

   task automatic test_det_dependence();
      int cyc;
      data[31:24] = 8'h00; req = 4'b1000;
      tick(); force_hi = 1'b1;
      tick(); force_hi = 1'b1;
      tick(); force_hi = 1'b0;
      wait_done(cyc);
      req = '0;
      checks++;
      if (cyc != 8 || count !== 3'd0 || grant !== 4'b1000) begin
         errors++;
         $display("FAIL det_dep cyc=%0d count=%0d grant=%b exp 8/0/1000", cyc, count, grant);
      end
      tick();
   endtask

   initial begin
      errors = 0; checks = 0;
      force_hi = 1'b0; rst = 1'b0; req = '0; data = '0;
      test_reset();
      test_single_ff();
      test_patterns();
      test_round_robin();
      test_withdrawal();
      test_reset_mid_shift();
      test_det_dependence();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

endmodule
